// File: rtl/gtxe2_chnl_outclk_defs.sv
`default_nettype none
// ============================================================================
//  Module      : gtxe2_chnl_outclk_defs (package)
//  Description : Shared definitions for the channel output-clock blocks:
//                switch FSM state encodings, the idle select code and the
//                parameter legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package gtxe2_chnl_outclk_defs;

   // Switch sequencer states. IDLE is the only state that accepts requests.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GATE   = 2'd1,
      ST_SWAP   = 2'd2,
      ST_SETTLE = 2'd3
   } outclk_state_e;

   // Select code 0 parks the output at its idle level instead of a source.
   localparam int unsigned SEL_CODE_IDLE = 0;

   // True when the parameter set describes a buildable switch.
   function automatic bit outclk_params_legal(
      input int unsigned num_src,
      input int unsigned sel_w,
      input int unsigned gate_cycles,
      input int unsigned settle_cycles,
      input int unsigned reset_sel
   );
      bit ok;
      ok = 1'b1;
      if (sel_w < 1 || sel_w > 16)                  ok = 1'b0;
      if (num_src < 1)                              ok = 1'b0;
      if (sel_w <= 16 && num_src > (32'd1 << sel_w) - 32'd1) ok = 1'b0;
      if (gate_cycles < 1)                          ok = 1'b0;
      if (settle_cycles < 1)                        ok = 1'b0;
      if (reset_sel > num_src)                      ok = 1'b0;
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gtxe2_chnl_outclk_mux_n.sv
`default_nettype none
// ============================================================================
//  Module      : gtxe2_chnl_outclk_mux_n
//  Description : Stateless N-way gated clock mux. Code k (1..NUM_SRC) passes
//                clk_in_i[k-1]; code 0 or an asserted gate drives IDLE_LEVEL.
//  Revision    : 1.0 - initial release
// ============================================================================
module gtxe2_chnl_outclk_mux_n
   import gtxe2_chnl_outclk_defs::*;
#(
   parameter int unsigned NUM_SRC    = 4,
   parameter int unsigned SEL_W      = 3,
   parameter logic        IDLE_LEVEL = 1'b1
) (
   input  logic [NUM_SRC-1:0] clk_in_i,
   input  logic [SEL_W-1:0]   sel_i,
   input  logic               gate_i,
   output logic               clk_o
);

   // Pure combinational select; the only path from the source clocks.
   always_comb begin
      clk_o = IDLE_LEVEL;
      if (!gate_i && sel_i != SEL_W'(SEL_CODE_IDLE)) begin
         for (int k = 0; k < int'(NUM_SRC); k++) begin
            if (sel_i == SEL_W'(k + 1)) begin
               clk_o = clk_in_i[k];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/gtxe2_chnl_outclk_switch.sv
`default_nettype none
// ============================================================================
//  Module      : gtxe2_chnl_outclk_switch
//  Description : Glitch-masking TXOUTCLK source switch. A request is gated for
//                GATE_CYCLES, swapped in one cycle, then held for
//                SETTLE_CYCLES before the output is released. Simulation
//                model only; not a synthesisable clock switch.
//  Revision    : 1.0 - initial release
// ============================================================================
module gtxe2_chnl_outclk_switch
   import gtxe2_chnl_outclk_defs::*;
#(
   parameter int unsigned NUM_SRC       = 4,
   parameter int unsigned SEL_W         = 3,
   parameter int unsigned GATE_CYCLES   = 4,
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter logic        IDLE_LEVEL    = 1'b1,
   parameter int unsigned RESET_SEL     = 0
) (
   input  logic               DRPCLK,
   input  logic               GTTXRESET,
   input  logic [NUM_SRC-1:0] CLK_IN,
   input  logic [SEL_W-1:0]   SEL_REQ,
   input  logic               SEL_REQ_VALID,
   output logic               SEL_REQ_READY,
   output logic [SEL_W-1:0]   SEL_ACTIVE,
   output logic               SWITCHING,
   output logic               SEL_DONE,
   output logic               SEL_ERR,
   output logic               TXOUTCLK
);

   localparam bit          PARAMS_OK = outclk_params_legal(NUM_SRC, SEL_W, GATE_CYCLES,
                                                           SETTLE_CYCLES, RESET_SEL);
   localparam int unsigned CNT_MAX   = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES
                                                                     : SETTLE_CYCLES;
   localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [SEL_W-1:0] MAX_CODE    = SEL_W'(NUM_SRC);
   localparam logic [SEL_W-1:0] RST_CODE    = SEL_W'(RESET_SEL);

   generate
      if (!PARAMS_OK) begin : g_param_err
         $error("gtxe2_chnl_outclk_switch: illegal parameter set");
      end
   endgenerate

   outclk_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SEL_W-1:0] sel_act_q, sel_act_d;
   logic [SEL_W-1:0] sel_pend_q, sel_pend_d;
   logic             switching_q, switching_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             rdy_en_q;
   logic             w_ready;
   logic             w_accept;

   // READY is held low through reset and for the edge that releases it.
   assign w_ready  = (state_q == ST_IDLE) && rdy_en_q;
   assign w_accept = w_ready && SEL_REQ_VALID;

   // Sequencer next-state and registered-output decode.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sel_act_d   = sel_act_q;
      sel_pend_d  = sel_pend_q;
      switching_d = switching_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               if (SEL_REQ > MAX_CODE) begin
                  err_d = 1'b1;
               end else if (SEL_REQ == sel_act_q) begin
                  done_d = 1'b1;
               end else begin
                  sel_pend_d  = SEL_REQ;
                  cnt_d       = GATE_LOAD;
                  switching_d = 1'b1;
                  state_d     = ST_GATE;
               end
            end
         end
         ST_GATE: begin
            if (cnt_q == '0) begin
               state_d = ST_SWAP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_SWAP: begin
            sel_act_d = sel_pend_q;
            cnt_d     = SETTLE_LOAD;
            state_d   = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               switching_d = 1'b0;
               done_d      = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control registers; reset discards any in-flight request.
   always_ff @(posedge DRPCLK) begin
      if (GTTXRESET) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         sel_act_q   <= RST_CODE;
         sel_pend_q  <= RST_CODE;
         switching_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         rdy_en_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sel_act_q   <= sel_act_d;
         sel_pend_q  <= sel_pend_d;
         switching_q <= switching_d;
         done_q      <= done_d;
         err_q       <= err_d;
         rdy_en_q    <= 1'b1;
      end
   end

   gtxe2_chnl_outclk_mux_n #(
      .NUM_SRC    (NUM_SRC),
      .SEL_W      (SEL_W),
      .IDLE_LEVEL (IDLE_LEVEL)
   ) u_mux (
      .clk_in_i (CLK_IN),
      .sel_i    (sel_act_q),
      .gate_i   (switching_q),
      .clk_o    (TXOUTCLK)
   );

   assign SEL_REQ_READY = w_ready;
   assign SEL_ACTIVE    = sel_act_q;
   assign SWITCHING     = switching_q;
   assign SEL_DONE      = done_q;
   assign SEL_ERR       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_gtxe2_chnl_outclk_switch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gtxe2_chnl_outclk_switch
//  Description : Directed bench for the TXOUTCLK switch. Instance 0 uses the
//                default timing, instance 1 uses GATE_CYCLES=SETTLE_CYCLES=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gtxe2_chnl_outclk_switch;

   logic       DRPCLK;
   logic [3:0] clk_src;
   logic [1:0] rst, vld, rdy, sw, done, err, txo;
   logic [2:0] req [2];
   logic [2:0] act [2];

   int n_tests = 0;
   int n_fail  = 0;
   int gc [2]  = '{4, 1};
   int sc [2]  = '{8, 1};

   gtxe2_chnl_outclk_switch u_dut_def (
      .DRPCLK(DRPCLK), .GTTXRESET(rst[0]), .CLK_IN(clk_src),
      .SEL_REQ(req[0]), .SEL_REQ_VALID(vld[0]), .SEL_REQ_READY(rdy[0]),
      .SEL_ACTIVE(act[0]), .SWITCHING(sw[0]), .SEL_DONE(done[0]),
      .SEL_ERR(err[0]), .TXOUTCLK(txo[0])
   );

   gtxe2_chnl_outclk_switch #(.GATE_CYCLES(1), .SETTLE_CYCLES(1)) u_dut_fast (
      .DRPCLK(DRPCLK), .GTTXRESET(rst[1]), .CLK_IN(clk_src),
      .SEL_REQ(req[1]), .SEL_REQ_VALID(vld[1]), .SEL_REQ_READY(rdy[1]),
      .SEL_ACTIVE(act[1]), .SWITCHING(sw[1]), .SEL_DONE(done[1]),
      .SEL_ERR(err[1]), .TXOUTCLK(txo[1])
   );

   // Control clock: posedges at 10+20n; samples land on odd times.
   initial begin
      DRPCLK = 1'b0;
      forever #10 DRPCLK = ~DRPCLK;
   end

   // Source clocks toggle only on even times so samples never race them.
   initial clk_src = 4'b0000;
   always #2 clk_src[0] = ~clk_src[0];
   always #4 clk_src[1] = ~clk_src[1];
   always #6 clk_src[2] = ~clk_src[2];
   always #8 clk_src[3] = ~clk_src[3];

   task automatic step();
      @(posedge DRPCLK);
      #1;
   endtask

   task automatic test_reset(input int d);
      rst[d] = 1'b1; vld[d] = 1'b0; req[d] = 3'd0;
      step(); step();
      n_tests++; if (rdy[d] !== 1'b0) begin n_fail++; $display("FAIL rst_ready[%0d] got %b want 0", d, rdy[d]); end
      n_tests++; if (act[d] !== 3'd0) begin n_fail++; $display("FAIL rst_active[%0d] got %0d want 0", d, act[d]); end
      n_tests++; if (sw[d] !== 1'b0 || done[d] !== 1'b0 || err[d] !== 1'b0) begin
         n_fail++; $display("FAIL rst_flags[%0d] got sw=%b done=%b err=%b want 0/0/0", d, sw[d], done[d], err[d]);
      end
      n_tests++; if (txo[d] !== 1'b1) begin n_fail++; $display("FAIL rst_txo[%0d] got %b want 1", d, txo[d]); end
      rst[d] = 1'b0;
      n_tests++; if (rdy[d] !== 1'b0) begin n_fail++; $display("FAIL rel_ready_early[%0d] got %b want 0", d, rdy[d]); end
      step();
      n_tests++; if (rdy[d] !== 1'b1) begin n_fail++; $display("FAIL rel_ready[%0d] got %b want 1", d, rdy[d]); end
      n_tests++; if (act[d] !== 3'd0 || txo[d] !== 1'b1) begin
         n_fail++; $display("FAIL rel_state[%0d] got act=%0d txo=%b want 0/1", d, act[d], txo[d]);
      end
   endtask

   task automatic test_switch(input int d, input logic [2:0] from, input logic [2:0] to);
      int last;
      logic e_sw;
      logic [2:0] e_act;
      last = gc[d] + sc[d] + 1;
      n_tests++; if (act[d] !== from) begin n_fail++; $display("FAIL sw_pre[%0d] got %0d want %0d", d, act[d], from); end
      req[d] = to; vld[d] = 1'b1;
      step();
      vld[d] = 1'b0;
      for (int k = 0; k <= last; k++) begin
         e_sw  = (k < last);
         e_act = (k >= gc[d] + 1) ? to : from;
         n_tests++; if (sw[d] !== e_sw) begin n_fail++; $display("FAIL sw_switching[%0d] k=%0d got %b want %b", d, k, sw[d], e_sw); end
         n_tests++; if (act[d] !== e_act) begin n_fail++; $display("FAIL sw_active[%0d] k=%0d got %0d want %0d", d, k, act[d], e_act); end
         n_tests++; if (done[d] !== (k == last)) begin n_fail++; $display("FAIL sw_done[%0d] k=%0d got %b want %b", d, k, done[d], (k == last)); end
         n_tests++; if (rdy[d] !== !e_sw || err[d] !== 1'b0) begin
            n_fail++; $display("FAIL sw_ready_err[%0d] k=%0d got rdy=%b err=%b want %b/0", d, k, rdy[d], err[d], !e_sw);
         end
         if (e_sw) begin
            n_tests++; if (txo[d] !== 1'b1) begin n_fail++; $display("FAIL sw_gated_txo[%0d] k=%0d got %b want 1", d, k, txo[d]); end
         end
         if (k != last) step();
      end
      for (int j = 0; j < 8; j++) begin
         #2;
         n_tests++;
         if (to == 3'd0) begin
            if (txo[d] !== 1'b1) begin n_fail++; $display("FAIL sw_follow[%0d] j=%0d got %b want 1", d, j, txo[d]); end
         end else if (txo[d] !== clk_src[to - 3'd1]) begin
            n_fail++; $display("FAIL sw_follow[%0d] j=%0d got %b want %b", d, j, txo[d], clk_src[to - 3'd1]);
         end
      end
      step();
   endtask

   task automatic test_same_code(input int d, input logic [2:0] code);
      req[d] = code; vld[d] = 1'b1;
      step();
      vld[d] = 1'b0;
      n_tests++; if (done[d] !== 1'b1 || err[d] !== 1'b0) begin
         n_fail++; $display("FAIL same_done[%0d] got done=%b err=%b want 1/0", d, done[d], err[d]);
      end
      n_tests++; if (sw[d] !== 1'b0 || act[d] !== code || rdy[d] !== 1'b1) begin
         n_fail++; $display("FAIL same_state[%0d] got sw=%b act=%0d rdy=%b want 0/%0d/1", d, sw[d], act[d], rdy[d], code);
      end
      step();
      n_tests++; if (done[d] !== 1'b0 || sw[d] !== 1'b0) begin
         n_fail++; $display("FAIL same_after[%0d] got done=%b sw=%b want 0/0", d, done[d], sw[d]);
      end
   endtask

   task automatic test_err(input int d, input logic [2:0] cur);
      req[d] = 3'd7; vld[d] = 1'b1;
      step();
      vld[d] = 1'b0;
      n_tests++; if (err[d] !== 1'b1 || done[d] !== 1'b0) begin
         n_fail++; $display("FAIL err_pulse[%0d] got err=%b done=%b want 1/0", d, err[d], done[d]);
      end
      n_tests++; if (act[d] !== cur || sw[d] !== 1'b0) begin
         n_fail++; $display("FAIL err_state[%0d] got act=%0d sw=%b want %0d/0", d, act[d], sw[d], cur);
      end
      step();
      n_tests++; if (err[d] !== 1'b0 || done[d] !== 1'b0) begin
         n_fail++; $display("FAIL err_after[%0d] got err=%b done=%b want 0/0", d, err[d], done[d]);
      end
   endtask

   task automatic test_reset_abort(input int d);
      req[d] = 3'd3; vld[d] = 1'b1;
      step();
      vld[d] = 1'b0;
      for (int k = 0; k < gc[d] + 1; k++) step();
      n_tests++; if (act[d] !== 3'd3 || sw[d] !== 1'b1) begin
         n_fail++; $display("FAIL abort_settle[%0d] got act=%0d sw=%b want 3/1", d, act[d], sw[d]);
      end
      rst[d] = 1'b1;
      step();
      n_tests++; if (act[d] !== 3'd0 || sw[d] !== 1'b0 || done[d] !== 1'b0 || rdy[d] !== 1'b0) begin
         n_fail++; $display("FAIL abort_reset[%0d] got act=%0d sw=%b done=%b rdy=%b want 0/0/0/0", d, act[d], sw[d], done[d], rdy[d]);
      end
      rst[d] = 1'b0;
      for (int k = 0; k < gc[d] + sc[d] + 3; k++) begin
         step();
         n_tests++; if (done[d] !== 1'b0 || sw[d] !== 1'b0 || act[d] !== 3'd0) begin
            n_fail++; $display("FAIL abort_quiet[%0d] k=%0d got done=%b sw=%b act=%0d want 0/0/0", d, k, done[d], sw[d], act[d]);
         end
      end
   endtask

   task automatic test_back_to_back(input int d);
      int last;
      last = gc[d] + sc[d] + 1;
      req[d] = 3'd3; vld[d] = 1'b1;
      step();
      req[d] = 3'd1;
      for (int k = 0; k <= last; k++) begin
         n_tests++; if (rdy[d] !== (k == last) || done[d] !== (k == last)) begin
            n_fail++; $display("FAIL b2b_hold[%0d] k=%0d got rdy=%b done=%b want %b/%b", d, k, rdy[d], done[d], (k == last), (k == last));
         end
         step();
      end
      vld[d] = 1'b0;
      n_tests++; if (sw[d] !== 1'b1 || act[d] !== 3'd3 || done[d] !== 1'b0) begin
         n_fail++; $display("FAIL b2b_accept[%0d] got sw=%b act=%0d done=%b want 1/3/0", d, sw[d], act[d], done[d]);
      end
      for (int k = 0; k < gc[d] + 1; k++) step();
      n_tests++; if (act[d] !== 3'd1 || sw[d] !== 1'b1) begin
         n_fail++; $display("FAIL b2b_swap[%0d] got act=%0d sw=%b want 1/1", d, act[d], sw[d]);
      end
      for (int k = 0; k < sc[d]; k++) step();
      n_tests++; if (done[d] !== 1'b1 || sw[d] !== 1'b0) begin
         n_fail++; $display("FAIL b2b_done[%0d] got done=%b sw=%b want 1/0", d, done[d], sw[d]);
      end
      step();
   endtask

   initial begin
      rst = 2'b11; vld = 2'b00;
      req[0] = 3'd0; req[1] = 3'd0;
      for (int d = 0; d < 2; d++) begin
         test_reset(d);
         test_switch(d, 3'd0, 3'd2);
         test_same_code(d, 3'd2);
         test_err(d, 3'd2);
         test_reset_abort(d);
         test_same_code(d, 3'd0);
         test_back_to_back(d);
         test_switch(d, 3'd1, 3'd0);
         test_switch(d, 3'd0, 3'd4);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("FAIL timeout tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/gtxe2_chnl_outclk_switch.md
GTXE2_CHNL_OUTCLK_SWITCH -- requirements
Module: gtxe2_chnl_outclk_switch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock DRPCLK, reset GTTXRESET.
REQ-002 Parameter NUM_SRC, default 4, SHALL set the number of selectable clock sources (range 1..2**SEL_W-1).
REQ-003 Parameter SEL_W, default 3, SHALL set the select code width.
REQ-004 Parameter GATE_CYCLES, default 4, SHALL set the number of DRPCLK cycles the output is held before the source swap (minimum 1).
REQ-005 Parameter SETTLE_CYCLES, default 8, SHALL set the number of DRPCLK cycles the output is held after the source swap (minimum 1).
REQ-006 Parameter IDLE_LEVEL, default 1'b1, SHALL set the constant driven on TXOUTCLK while gated or while code 0 is active.
REQ-007 Parameter RESET_SEL, default 0, SHALL set the active select code after reset.
REQ-008 Ports SHALL be:
- DRPCLK  in  1  control clock
- GTTXRESET  in  1  sync reset, active high
- CLK_IN  in  NUM_SRC  source clocks; code k selects CLK_IN[k-1]
- SEL_REQ  in  SEL_W  requested select code
- SEL_REQ_VALID  in  1  request strobe
- SEL_REQ_READY  out  1  request accepted when VALID and READY are both high at a DRPCLK edge
- SEL_ACTIVE  out  SEL_W  currently applied select code
- SWITCHING  out  1  output gated, switch in progress
- SEL_DONE  out  1  one-cycle pulse when a request completes
- SEL_ERR  out  1  one-cycle pulse when an out-of-range code is rejected
- TXOUTCLK  out  1  muxed output clock

Function
REQ-009 TXOUTCLK SHALL be IDLE_LEVEL when SWITCHING=1 or SEL_ACTIVE=0, and CLK_IN[SEL_ACTIVE-1] otherwise; this path SHALL be combinational from CLK_IN, with all select and gate controls registered on DRPCLK.
REQ-010 The FSM SHALL have the states IDLE, GATE, SWAP and SETTLE; SEL_REQ_READY SHALL be 1 only in IDLE.
REQ-011 When a request with code in 1..NUM_SRC that differs from SEL_ACTIVE is accepted, the block SHALL latch the code, enter GATE, set SWITCHING=1 and load its counter with GATE_CYCLES-1.
REQ-012 In GATE, the counter SHALL decrement each cycle and the FSM SHALL go to SWAP on the edge where the count is 0.
REQ-013 In SWAP, SEL_ACTIVE SHALL be loaded with the latched code, the counter SHALL be loaded with SETTLE_CYCLES-1, and the FSM SHALL go to SETTLE after one cycle.
REQ-014 In SETTLE, the counter SHALL decrement each cycle; on the edge where the count is 0, the FSM SHALL return to IDLE, clear SWITCHING and pulse SEL_DONE.
REQ-015 SWITCHING SHALL stay high for exactly GATE_CYCLES+1+SETTLE_CYCLES cycles.
REQ-016 SEL_DONE SHALL assert GATE_CYCLES+SETTLE_CYCLES+1 edges after the accepting edge.
REQ-017 An accepted code equal to SEL_ACTIVE, including 0, SHALL cause no gating and SHALL pulse SEL_DONE on the next cycle.
REQ-018 An accepted code 0 that differs from SEL_ACTIVE SHALL follow the full GATE/SWAP/SETTLE sequence.
REQ-019 An accepted code greater than NUM_SRC SHALL be consumed, SHALL pulse SEL_ERR on the next cycle, and SHALL leave SEL_ACTIVE, SWITCHING and SEL_DONE unchanged.
REQ-020 A new request SHALL be acceptable in the same cycle that SEL_DONE is high, because READY is high in IDLE.
REQ-021 SEL_REQ_VALID while busy SHALL be ignored, with no queuing; the requester SHALL hold VALID until READY.
REQ-022 SEL_DONE and SEL_ERR SHALL never be high in the same cycle.

Reset
REQ-023 While GTTXRESET=1 at an edge, the block SHALL set: state IDLE, SEL_ACTIVE=RESET_SEL, SWITCHING=0, SEL_DONE=0, SEL_ERR=0, counter=0, SEL_REQ_READY=0.
REQ-024 Reset asserted mid-switch SHALL abort the sequence with no SEL_DONE; the latched request SHALL be discarded.
REQ-025 SEL_REQ_READY SHALL rise on the first edge after GTTXRESET deasserts.

Structure
REQ-026 The FSM state encodings, the select code 0 (idle) and the parameter legality checks SHALL live in a shared include, gtxe2_chnl_outclk_defs, that later channel clock blocks also use.
REQ-027 The N-way gated mux SHALL be a sub-module, gtxe2_chnl_outclk_mux_n, parametrised on NUM_SRC, SEL_W and IDLE_LEVEL, and SHALL contain no state.
REQ-028 The module SHALL be simulation-oriented and SHALL NOT be used as a synthesisable clock switch.

Verification
REQ-029 Reset with RESET_SEL=0 -> TXOUTCLK=1, SEL_ACTIVE=0, READY=1 one cycle after reset release.
REQ-030 Request 2 from 0 with defaults -> SWITCHING high for exactly 13 cycles, SEL_ACTIVE=2 after 5 edges, SEL_DONE 13 edges after accept, then TXOUTCLK follows CLK_IN[1].
REQ-031 Request 2 while SEL_ACTIVE=2 -> SEL_DONE the next cycle, SWITCHING never asserts.
REQ-032 Request 7 with NUM_SRC=4 -> SEL_ERR pulse, SEL_ACTIVE unchanged, no SEL_DONE.
REQ-033 Request 3, then GTTXRESET asserted during SETTLE -> SEL_ACTIVE=RESET_SEL, SWITCHING=0, no SEL_DONE; request 1 with VALID held through the busy period -> accepted only on the SEL_DONE cycle.
REQ-034 All scenarios SHALL be repeated with GATE_CYCLES=1 and SETTLE_CYCLES=1 -> SWITCHING high for 3 cycles.
